// File: rtl/bcd_time_counter.sv
// hh:mm:ss time counter with packed BCD output, prescaled 1 s tick,
// checked load and pause. Define HOUR12_EN for 12-hour mode with pm flag.
// Ports: clk, rst (async, active-high), en (run enable), load (strobe),
//   load_bcd[23:0] {h_t,h_u,m_t,m_u,s_t,s_u}, time_bcd[23:0] (registered),
//   update (new-value pulse), load_err (rejected-load pulse), pm.
module bcd_time_counter #(
  parameter int TIME_1S = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [23:0] load_bcd,
  output logic [23:0] time_bcd,
  output logic        update,
  output logic        load_err,
  output logic        pm
);

  localparam int PW = $clog2(TIME_1S);
  localparam logic [PW-1:0] LAST = PW'(TIME_1S - 1);

`ifdef HOUR12_EN
  localparam logic [23:0] RST_TIME = 24'h120000;
`else
  localparam logic [23:0] RST_TIME = 24'h000000;
`endif

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_inc;
  logic          tick;

  assign tick      = en && (presc == LAST);
  assign presc_inc = tick ? '0 : presc + 1'b1;

  logic [3:0] h_t, h_u, m_t, m_u, s_t, s_u;
  assign {h_t, h_u, m_t, m_u, s_t, s_u} = time_bcd;

  // Carry chain: each stage rolls only when every lower digit is at max.
  logic su_max, st_max, mu_max, mt_max;
  assign su_max = (s_u == 4'd9);
  assign st_max = su_max && (s_t == 4'd5);
  assign mu_max = st_max && (m_u == 4'd9);
  assign mt_max = mu_max && (m_t == 4'd5);

  logic [3:0] n_ht, n_hu, n_mt, n_mu, n_st, n_su;
  logic       pm_flip;

  always_comb begin
    n_su    = su_max ? 4'd0 : s_u + 4'd1;
    n_st    = s_t;
    n_mu    = m_u;
    n_mt    = m_t;
    n_ht    = h_t;
    n_hu    = h_u;
    pm_flip = 1'b0;
    if (su_max) n_st = (s_t == 4'd5) ? 4'd0 : s_t + 4'd1;
    if (st_max) n_mu = (m_u == 4'd9) ? 4'd0 : m_u + 4'd1;
    if (mu_max) n_mt = (m_t == 4'd5) ? 4'd0 : m_t + 4'd1;
    if (mt_max) begin
`ifdef HOUR12_EN
      if (h_t == 4'd1 && h_u == 4'd2) begin
        n_ht = 4'd0;
        n_hu = 4'd1;
      end else if (h_t == 4'd1 && h_u == 4'd1) begin
        n_ht    = 4'd1;
        n_hu    = 4'd2;
        pm_flip = 1'b1;
      end else if (h_u == 4'd9) begin
        n_ht = h_t + 4'd1;
        n_hu = 4'd0;
      end else begin
        n_hu = h_u + 4'd1;
      end
`else
      if (h_t == 4'd2 && h_u == 4'd3) begin
        n_ht = 4'd0;
        n_hu = 4'd0;
      end else if (h_u == 4'd9) begin
        n_ht = h_t + 4'd1;
        n_hu = 4'd0;
      end else begin
        n_hu = h_u + 4'd1;
      end
`endif
    end
  end

  logic [3:0] l_ht, l_hu, l_mt, l_mu, l_st, l_su;
  assign {l_ht, l_hu, l_mt, l_mu, l_st, l_su} = load_bcd;

  logic load_ok;
  logic low_ok;
  assign low_ok = (l_su <= 4'd9) && (l_st <= 4'd5)
               && (l_mu <= 4'd9) && (l_mt <= 4'd5)
               && (l_hu <= 4'd9);

`ifdef HOUR12_EN
  assign load_ok = low_ok && (l_ht <= 4'd1)
                && !(l_ht == 4'd1 && l_hu > 4'd2)
                && !(l_ht == 4'd0 && l_hu == 4'd0);
`else
  assign load_ok = low_ok && (l_ht <= 4'd2)
                && !(l_ht == 4'd2 && l_hu > 4'd3);
`endif

  logic pm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      time_bcd <= RST_TIME;
      update   <= 1'b0;
      load_err <= 1'b0;
      pm_q     <= 1'b0;
    end else if (load) begin
      // A load always swallows a coincident tick.
      if (load_ok) begin
        presc    <= '0;
        time_bcd <= load_bcd;
        update   <= (load_bcd != time_bcd);
        load_err <= 1'b0;
      end else begin
        if (en) presc <= presc_inc;
        update   <= 1'b0;
        load_err <= 1'b1;
      end
    end else begin
      load_err <= 1'b0;
      update   <= tick;
      if (en) presc <= presc_inc;
      if (tick) begin
        time_bcd <= {n_ht, n_hu, n_mt, n_mu, n_st, n_su};
        if (pm_flip) pm_q <= ~pm_q;
      end
    end
  end

`ifdef HOUR12_EN
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with a seconds-of-day reference
// model; define HOUR12_EN to exercise the 12-hour build.
module tb_bcd_time_counter;

  localparam int T = 5;

`ifdef HOUR12_EN
  localparam bit H12 = 1'b1;
`else
  localparam bit H12 = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [23:0] load_bcd = '0;
  logic [23:0] time_bcd;
  logic        update;
  logic        load_err;
  logic        pm;

  int checks = 0;
  int failures = 0;

  bcd_time_counter #(.TIME_1S(T)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .load_bcd(load_bcd),
    .time_bcd(time_bcd),
    .update(update),
    .load_err(load_err),
    .pm(pm)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [23:0] act, logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: absolute seconds of a 24 h day plus prescaler count.
  int m_secs = 0;
  int m_pres = 0;
  bit m_upd = 0;
  bit m_err = 0;

  function automatic logic [23:0] to_bcd(int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    if (H12) h = (h % 12 == 0) ? 12 : h % 12;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10),
            4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  always @(posedge clk or posedge rst) begin
    int d[6];
    int hh, mm, ss, ns;
    bit ok;
    if (rst) begin
      m_secs = 0;
      m_pres = 0;
      m_upd  = 0;
      m_err  = 0;
    end else begin
      m_upd = 0;
      m_err = 0;
      if (load) begin
        for (int i = 0; i < 6; i++) d[i] = int'(load_bcd[23-4*i -: 4]);
        hh = d[0] * 10 + d[1];
        mm = d[2] * 10 + d[3];
        ss = d[4] * 10 + d[5];
        ok = 1;
        for (int i = 0; i < 6; i++) if (d[i] > 9) ok = 0;
        if (d[2] > 5 || d[4] > 5) ok = 0;
        if (H12) begin
          if (hh < 1 || hh > 12) ok = 0;
        end else begin
          if (hh > 23) ok = 0;
        end
        if (ok) begin
          if (H12) hh = (hh % 12) + ((m_secs >= 43200) ? 12 : 0);
          ns = hh * 3600 + mm * 60 + ss;
          m_upd = (ns != m_secs);
          m_secs = ns;
          m_pres = 0;
        end else begin
          m_err = 1;
          if (en) m_pres = (m_pres + 1) % T;
        end
      end else if (en) begin
        if (m_pres == T - 1) begin
          m_pres = 0;
          m_secs = (m_secs + 1) % 86400;
          m_upd = 1;
        end else begin
          m_pres++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("time_bcd", time_bcd, to_bcd(m_secs));
    chk("update", 24'(update), 24'(m_upd));
    chk("load_err", 24'(load_err), 24'(m_err));
    chk("pm", 24'(pm), (H12 && m_secs >= 43200) ? 24'd1 : 24'd0);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(logic [23:0] v);
    load = 1'b1;
    load_bcd = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    int pulses, last;
    logic [23:0] rt;
    rt = H12 ? 24'h120000 : 24'h000000;

    cyc(2);
    chk("reset_time", time_bcd, rt);
    chk("reset_pm", 24'(pm), 24'd0);
    rst = 1'b0;

    // Free run: ten increments, one every T cycles.
    en = 1'b1;
    pulses = 0;
    last = 0;
    for (int i = 1; i <= 50; i++) begin
      cyc(1);
      if (update) begin
        if (pulses == 0) chk("first_inc_at", 24'(i), 24'd5);
        else chk("inc_spacing", 24'(i - last), 24'd5);
        pulses++;
        last = i;
      end
    end
    chk("run50_time", time_bcd, H12 ? 24'h120010 : 24'h000010);
    chk("run50_pulses", 24'(pulses), 24'd10);

`ifndef HOUR12_EN
    do_load(24'h235958);
    cyc(5);
    chk("to_235959", time_bcd, 24'h235959);
    cyc(5);
    chk("wrap_000000", time_bcd, 24'h000000);
    chk("wrap_update", 24'(update), 24'd1);
`endif

    // Rejected loads while paused.
    en = 1'b0;
    rt = time_bcd;
    do_load(24'h240000);
    chk("err_240000", 24'(load_err), 24'd1);
    chk("err_keep1", time_bcd, rt);
    do_load(24'h006000);
    chk("err_006000", 24'(load_err), 24'd1);
    chk("err_keep2", time_bcd, rt);
    cyc(1);
    chk("err_one_cycle", 24'(load_err), 24'd0);

    // Pause with prescaler at 3.
    en = 1'b1;
    do_load(24'h101010);
    chk("load_101010", time_bcd, 24'h101010);
    cyc(3);
    en = 1'b0;
    cyc(20);
    chk("pause_hold", time_bcd, 24'h101010);
    en = 1'b1;
    cyc(1);
    chk("resume_no_inc", 24'(update), 24'd0);
    cyc(1);
    chk("resume_inc", time_bcd, 24'h101011);
    chk("resume_update", 24'(update), 24'd1);

    // Load coincident with a tick.
    cyc(4);
    do_load(24'h120000);
    chk("load_wins", time_bcd, 24'h120000);
    cyc(4);
    chk("after_load_hold", time_bcd, 24'h120000);
    cyc(1);
    chk("after_load_inc", time_bcd, 24'h120001);

    // Same-value load gives no update.
    en = 1'b0;
    do_load(24'h120001);
    chk("same_load_noupd", 24'(update), 24'd0);
    en = 1'b1;

`ifdef HOUR12_EN
    do_load(24'h115959);
    cyc(5);
    chk("h12_noon", time_bcd, 24'h120000);
    chk("h12_pm_set", 24'(pm), 24'd1);
    do_load(24'h125959);
    cyc(5);
    chk("h12_one", time_bcd, 24'h010000);
    chk("h12_pm_kept", 24'(pm), 24'd1);
    do_load(24'h000000);
    chk("h12_err_00", 24'(load_err), 24'd1);
`endif

    // Asynchronous reset mid-count.
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_time", time_bcd, H12 ? 24'h120000 : 24'h000000);
    chk("async_rst_upd", 24'(update), 24'd0);
    cyc(2);
    rst = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
